// File: rtl/mds_sequencer_pkg.sv
// Shared types for the multiply/divide sequencer: op codes, FSM states and
// the subset of ALU function encodings the sequencer drives onto the shared ALU.
package mds_sequencer_pkg;

  typedef enum logic [1:0] {
    MDS_MUL  = 2'b00,
    MDS_DIVU = 2'b01,
    MDS_REMU = 2'b10,
    MDS_RSVD = 2'b11
  } mds_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MUL_STEP = 2'b01,
    DIV_STEP = 2'b10,
    DONE     = 2'b11
  } mds_state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b1000
  } alu_src_t;

endpackage

// File: rtl/mds_sequencer.sv
// Iterative unsigned multiply / divide / remainder sequencer. Owns no adder:
// every add (multiply) and subtract (restoring divide) is borrowed from the shared ALU.
module mds_sequencer
  import mds_sequencer_pkg::*;
#(
  parameter int unsigned XLEN       = 16,
  parameter int unsigned EARLY_TERM = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [XLEN-1:0] req_a_i,
  input  logic [XLEN-1:0] req_b_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_data_o,
  output logic            busy_o,
  output logic            alu_req_o,
  input  logic            alu_gnt_i,
  output logic [XLEN-1:0] alu_rs1_o,
  output logic [XLEN-1:0] alu_rs2_o,
  output logic [3:0]      alu_func4_o,
  input  logic [XLEN-1:0] alu_result_i
);

  localparam int unsigned   CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  mds_state_t      state_q, state_d;
  mds_op_t         op_q, op_d;
  // work: accumulator (MUL) or partial remainder (DIV)
  // opnd: shifting multiplicand (MUL) or fixed divisor (DIV)
  // shft: shifting multiplier (MUL) or dividend/quotient register (DIV)
  logic [XLEN-1:0] work_q, work_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] shft_q, shft_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [XLEN:0]   div_t;
  logic            div_sub;
  logic            stall;

  always_comb begin
    div_t   = {work_q, shft_q[XLEN-1]};
    div_sub = div_t[XLEN] || (div_t[XLEN-1:0] >= opnd_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= MDS_MUL;
      work_q   <= '0;
      opnd_q   <= '0;
      shft_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      shft_q   <= shft_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    shft_d   = shft_q;
    result_d = result_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i && !flush_i) begin
          op_d   = mds_op_t'(req_op_i);
          work_d = '0;
          cnt_d  = '0;
          unique case (mds_op_t'(req_op_i))
            MDS_MUL: begin
              if (req_b_i == '0) begin
                result_d = '0;
                state_d  = DONE;
              end else begin
                opnd_d  = req_a_i;
                shft_d  = req_b_i;
                state_d = MUL_STEP;
              end
            end
            MDS_DIVU, MDS_REMU: begin
              if (req_b_i == '0) begin
                result_d = (mds_op_t'(req_op_i) == MDS_DIVU) ? '1 : req_a_i;
                state_d  = DONE;
              end else begin
                opnd_d  = req_b_i;
                shft_d  = req_a_i;
                state_d = DIV_STEP;
              end
            end
            default: begin
              result_d = '0;
              state_d  = DONE;
            end
          endcase
        end
      end
      MUL_STEP: begin
        if (!stall) begin
          work_d = shft_q[0] ? alu_result_i : work_q;
          opnd_d = opnd_q << 1;
          shft_d = shft_q >> 1;
          cnt_d  = cnt_q + 1'b1;
          if (((EARLY_TERM != 0) && (shft_d == '0)) || (cnt_q == LAST)) begin
            result_d = work_d;
            state_d  = DONE;
          end
        end
      end
      DIV_STEP: begin
        if (!stall) begin
          if (div_sub) begin
            work_d = alu_result_i;
            shft_d = {shft_q[XLEN-2:0], 1'b1};
          end else begin
            work_d = div_t[XLEN-1:0];
            shft_d = {shft_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            result_d = (op_q == MDS_DIVU) ? shft_d : work_d;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over any request, response handshake or step in flight.
    if (flush_i) state_d = IDLE;
  end

  always_comb begin
    req_ready_o  = (state_q == IDLE) && !flush_i;
    resp_valid_o = (state_q == DONE) && !flush_i;
    resp_data_o  = result_q;
    busy_o       = (state_q != IDLE);
    alu_req_o    = 1'b0;
    alu_rs1_o    = '0;
    alu_rs2_o    = '0;
    alu_func4_o  = '0;
    if (!flush_i) begin
      if (state_q == MUL_STEP && shft_q[0]) begin
        alu_req_o   = 1'b1;
        alu_rs1_o   = work_q;
        alu_rs2_o   = opnd_q;
        alu_func4_o = ALU_ADD;
      end else if (state_q == DIV_STEP && div_sub) begin
        alu_req_o   = 1'b1;
        alu_rs1_o   = div_t[XLEN-1:0];
        alu_rs2_o   = opnd_q;
        alu_func4_o = ALU_SUB;
      end
    end
    stall = alu_req_o && !alu_gnt_i;
  end

endmodule

// File: doc/mds_sequencer.md
Name: mds_sequencer

Overview:
- Iterative 16-bit unsigned multiply/divide sequencer that borrows the shared core ALU for its add/subtract steps instead of owning an adder.
- Sits beside the execute stage.
  - Accepts MUL/DIVU/REMU requests via valid/ready.
  - Requests ALU cycles through a req/gnt handshake; the pipeline arbiter owns priority.
  - Returns the result via valid/ready.
- Shifts and compares are local; only ADD (multiply) and SUB (divide) go to the ALU.

Parameters:
- XLEN, 16, datapath width; must match ALU width.
- EARLY_TERM, 1, 1 = multiply finishes when the remaining multiplier is zero; 0 = always 16 steps.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  kill in-flight op, no response
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_op_i  in  2  mds_op_t
- req_a_i  in  16  multiplicand / dividend
- req_b_i  in  16  multiplier / divisor
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  consumer accepts result
- resp_data_o  out  16  result
- busy_o  out  1  state != IDLE
- alu_req_o  out  1  ALU needed this cycle
- alu_gnt_i  in  1  ALU granted this cycle (combinational)
- alu_rs1_o  out  16  ALU operand A
- alu_rs2_o  out  16  ALU operand B
- alu_func4_o  out  4  riscv_pkg ADD or SUB encoding
- alu_result_i  in  16  ALU result, same cycle

Behaviour:
- Reset (async, rst_i=1) values:
  - state IDLE.
  - resp_valid_o=0, resp_data_o=0.
  - alu_req_o=0; alu_rs1_o, alu_rs2_o, alu_func4_o = 0.
  - busy_o=0; all internal registers 0.
- req_ready_o = (state==IDLE) && !flush_i.
- Accept cycle: latch operands.
  - MUL: acc=0, mcand=a, mplier=b.
  - DIVU/REMU: rem=0, quo=a, cnt=0.
- IDLE transitions on accept:
  - MUL with b==0 -> DONE, result 0.
  - DIVU/REMU with b==0 -> DONE. DIVU result 0xFFFF; REMU result a.
  - Reserved op 2'b11 -> DONE, result 0.
  - Otherwise MUL -> MUL_STEP; DIVU/REMU -> DIV_STEP.
- MUL_STEP, one multiplier bit per step:
  - If mplier[0]=1: alu_req_o=1, rs1=acc, rs2=mcand, func=ADD; acc<=alu_result_i.
  - Then mcand<<=1 and mplier>>=1.
  - Exit to DONE when (mplier>>1)==0 with EARLY_TERM=1, or after the 16th step.
  - Product wraps modulo 2^16.
- DIV_STEP (restoring division, one quotient bit per step):
  - t = {rem, quo[15]} (17 bits).
  - Subtract when t[16]=1 or t[15:0]>=b:
    - alu_req_o=1, rs1=t[15:0], rs2=b, func=SUB.
    - rem<=alu_result_i; quo<={quo[14:0],1}.
  - Otherwise no ALU use: rem<=t[15:0]; quo<={quo[14:0],0}.
  - After 16 steps -> DONE. Result is quo for DIVU, rem for REMU.
- Stall rule: a step with alu_req_o=1 and alu_gnt_i=0 changes no state.
  - ALU outputs hold; alu_req_o stays high until granted.
  - Steps needing no ALU never stall.
- ALU outputs are zero whenever alu_req_o=0.
- DONE: resp_valid_o=1, resp_data_o stable until resp_ready_i=1; then IDLE next cycle.
- Latency, gnt tied high, accept in cycle 0:
  - Zero/reserved cases: resp_valid_o in cycle 1.
  - DIVU/REMU: resp_valid_o in cycle 17.
  - MUL, EARLY_TERM=1: resp_valid_o in cycle (index of highest set bit of b)+2.
- flush_i=1 in any state: IDLE next cycle, resp_valid_o=0, alu_req_o=0 same cycle, no response. Flush beats a simultaneous request and a simultaneous resp_ready_i.
- rst_i mid-operation: immediate return to reset values; the op is lost.

Decomposition:
- riscv_pkg gains:
  - mds_op_t: MDS_MUL=2'b00, MDS_DIVU=2'b01, MDS_REMU=2'b10, 2'b11 reserved.
  - mds_state_t: IDLE, MUL_STEP, DIV_STEP, DONE.
- ALU encodings reuse the existing alu_src_t.
- No sub-module: the ALU stays external and shared; arbitration lives in the pipeline.

Test Plan:
- MUL a=0x0003 b=0x0005, gnt=1 -> alu_req_o high in cycles 1 and 3 only; resp 0x000F in cycle 4.
- MUL a=0x1234 b=0x0100 -> resp 0x3400 (wrap).
- MUL a=0xFFFF b=0 -> resp 0x0000 in cycle 1, alu_req_o never high.
- DIVU a=100 b=7 -> resp 14 in cycle 17. REMU same operands -> 2.
- DIVU a=0xFFFF b=1 -> 0xFFFF.
- DIVU a=5 b=0 -> 0xFFFF in cycle 1. REMU a=5 b=0 -> 5.
- DIVU 100/7 with alu_gnt_i low 3 cycles at the first ALU request -> operands held, resp 14 delayed exactly 3 cycles.
- resp_ready_i low 4 cycles -> data held.
- flush_i mid-DIV_STEP -> no resp_valid_o; next MUL 6*7 -> 42.
- rst_i pulsed mid-op -> all outputs 0 (req_ready_o=1 once rst_i drops).
